// File: rtl/uart_frame_rx.sv
// Receive framing stage: SYNC, command, N-bit payload (MSB byte first), XOR checksum.
// A validated {cmd, payload} is held on a valid/ready output; aborted frames pulse frame_err.
module uart_frame_rx #(
  parameter int          N       = 32,
  parameter int          TIMEOUT = 12000,
  parameter logic [7:0]  SYNC    = 8'hA5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rx_valid,
  input  logic [7:0]   rx_byte,
  input  logic         rx_error,
  output logic [N-1:0] tx_bytes,
  output logic [7:0]   tx_cmd,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         frame_err,
  output logic [1:0]   err_code,
  output logic         busy
);

  // Handshake: a frame transfers on every rising edge where tx_valid and tx_ready
  // are both high; tx_valid and the data stay stable until that edge.

  localparam int NB = N / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ERR_CSUM = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;
  localparam logic [1:0] ERR_LINE = 2'd3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    HOLD = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   sr_q, sr_d;
  logic [7:0]     cmd_q, cmd_d;
  logic [7:0]     csum_q, csum_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [N-1:0]   tx_bytes_q, tx_bytes_d;
  logic [7:0]     tx_cmd_q, tx_cmd_d;
  logic           tx_valid_q, tx_valid_d;
  logic           frame_err_q, frame_err_d;
  logic [1:0]     err_code_q, err_code_d;
  logic           busy_q, busy_d;

  logic in_frame;
  logic tmo_hit;
  logic is_sync;

  assign in_frame = (state_q == CMD) || (state_q == DATA) || (state_q == CSUM);
  assign tmo_hit  = in_frame && !rx_valid && (tmo_q == TW'(TIMEOUT - 1));
  assign is_sync  = rx_valid && (rx_byte == SYNC);

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cmd_d       = cmd_q;
    csum_d      = csum_q;
    cnt_d       = cnt_q;
    tx_bytes_d  = tx_bytes_q;
    tx_cmd_d    = tx_cmd_q;
    tx_valid_d  = tx_valid_q;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;

    // Entry to CMD always coincides with a byte strobe, so clearing on rx_valid covers it.
    if (rx_valid)      tmo_d = '0;
    else if (in_frame) tmo_d = TW'(tmo_q + TW'(1));
    else               tmo_d = '0;

    case (state_q)
      IDLE: begin
        if (is_sync) state_d = CMD;
      end
      HOLD: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = is_sync ? CMD : IDLE;
        end else if (rx_error || rx_valid) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_LINE;
        end
      end
      default: begin
        if (rx_error) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_LINE;
          state_d     = IDLE;
        end else if (tmo_hit) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_TMO;
          state_d     = IDLE;
        end else if (rx_valid) begin
          case (state_q)
            CMD: begin
              cmd_d   = rx_byte;
              csum_d  = rx_byte;
              cnt_d   = '0;
              state_d = DATA;
            end
            DATA: begin
              sr_d   = {sr_q[N-9:0], rx_byte};
              csum_d = csum_q ^ rx_byte;
              cnt_d  = CW'(cnt_q + CW'(1));
              if (cnt_q == CW'(NB - 1)) state_d = CSUM;
            end
            CSUM: begin
              if (rx_byte == csum_q) begin
                tx_bytes_d = sr_q;
                tx_cmd_d   = cmd_q;
                tx_valid_d = 1'b1;
                state_d    = HOLD;
              end else begin
                frame_err_d = 1'b1;
                err_code_d  = ERR_CSUM;
                state_d     = IDLE;
              end
            end
            default: state_d = IDLE;
          endcase
        end
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      cmd_q       <= '0;
      csum_q      <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      tx_bytes_q  <= '0;
      tx_cmd_q    <= '0;
      tx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cmd_q       <= cmd_d;
      csum_q      <= csum_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      tx_bytes_q  <= tx_bytes_d;
      tx_cmd_q    <= tx_cmd_d;
      tx_valid_q  <= tx_valid_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      busy_q      <= busy_d;
    end
  end

  assign tx_bytes  = tx_bytes_q;
  assign tx_cmd    = tx_cmd_q;
  assign tx_valid  = tx_valid_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign busy      = busy_q;

endmodule
